mem_burst_seq: RTL and testbench

- Burst sequencer directly upstream of the 16x8-bit memory bank array.
- Drives the shared read, write, address and data_in buses of the four byte-wide banks as one 32-bit word memory, and consumes the 32-bit data_out bus.
- Turns a start/mode/base/len command into a sequence of single-word accesses.
- Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream.

---
 rtl/mem_burst_seq.sv | 200 ++++++++++++++++++++
 tb/tb_mem_burst_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_seq.sv
// mem_burst_seq
//   Burst sequencer in front of the 16x8-bit bank array (four byte-wide banks
//   used together as one DATA_W-bit word memory). A start/mode/base/len
//   command is turned into single-word memory accesses. Write data comes in
//   on a valid/ready stream and read data leaves on a valid/ready stream.
//
//   Optional build macro: MEM_BURST_SEQ_STALL_CNT_EN adds rd_stall_cnt, a
//   saturating count of RD_HOLD cycles with rd_ready low, cleared on every
//   accepted start.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start/mode/base_addr/len command (sampled only in IDLE)
//   wr_valid/wr_data/wr_ready  write stream (wr_ready decoded from state)
//   rd_valid/rd_data/rd_ready  read stream
//   mem_read/mem_write/mem_address/mem_data_in/mem_data_out  memory bus
//   busy, done              status (done is a one-cycle pulse)
//   rd_stall_cnt            [macro only] read backpressure cycle count
//
// State table
//   S_IDLE       | waiting for start
//   S_WR_ACCEPT  | wr_ready high, waiting for a write word
//   S_WR_STROBE  | mem_write pulse for the captured word
//   S_RD_ISSUE   | set up mem_read and address
//   S_RD_CAPTURE | mem_read high, capture mem_data_out at the edge
//   S_RD_HOLD    | rd_valid high until rd_ready
//   S_FINISH     | done pulse, busy drops at the next edge
module mem_burst_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done
`ifdef MEM_BURST_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       rd_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACCEPT,
    S_WR_STROBE,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_RD_HOLD,
    S_FINISH
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_remain;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W:0]   w_len_clamped;
  logic              w_accept;
  logic              w_last;

  assign w_len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign w_accept      = (r_state == S_IDLE) && start;
  // remaining-word down-counter: terminal count 1 means the current word is the last
  assign w_last        = (r_remain == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_clamped == '0) w_state_next = S_FINISH;
          else if (mode)           w_state_next = S_RD_ISSUE;
          else                     w_state_next = S_WR_ACCEPT;
        end
      end
      S_WR_ACCEPT:  if (wr_valid) w_state_next = S_WR_STROBE;
      S_WR_STROBE:  w_state_next = w_last ? S_FINISH : S_WR_ACCEPT;
      S_RD_ISSUE:   w_state_next = S_RD_CAPTURE;
      S_RD_CAPTURE: w_state_next = S_RD_HOLD;
      S_RD_HOLD:    if (rd_ready) w_state_next = w_last ? S_FINISH : S_RD_ISSUE;
      S_FINISH:     w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_remain      <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // FINISH lasts exactly one cycle, so done tracks entry into it
      r_done <= (w_state_next == S_FINISH);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr    <= base_addr;
            r_remain <= w_len_clamped;
            r_busy   <= (w_len_clamped != '0);
          end
        end
        S_WR_ACCEPT: begin
          if (wr_valid) begin
            r_mem_data_in <= wr_data;
            r_mem_address <= r_ptr;
            r_mem_write   <= 1'b1;
          end
        end
        S_WR_STROBE: begin
          r_mem_write <= 1'b0;
          r_ptr       <= r_ptr + ADDR_W'(1);
          r_remain    <= r_remain - (ADDR_W+1)'(1);
        end
        S_RD_ISSUE: begin
          r_mem_read    <= 1'b1;
          r_mem_address <= r_ptr;
        end
        S_RD_CAPTURE: begin
          r_rd_data  <= mem_data_out;
          r_rd_valid <= 1'b1;
          r_mem_read <= 1'b0;
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_ptr      <= r_ptr + ADDR_W'(1);
            r_remain   <= r_remain - (ADDR_W+1)'(1);
          end
        end
        S_FINISH: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MEM_BURST_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_accept)
      r_stall_cnt <= '0;
    else if ((r_state == S_RD_HOLD) && !rd_ready && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign rd_stall_cnt = r_stall_cnt;
`endif

  assign wr_ready    = (r_state == S_WR_ACCEPT);
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_mem_burst_seq.sv
module tb_mem_burst_seq;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  len = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready = 1'b0;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        busy;
  logic        done;
`ifdef MEM_BURST_SEQ_STALL_CNT_EN
  logic [15:0] rd_stall_cnt;
`endif

  mem_burst_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .base_addr    (base_addr),
    .len          (len),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done)
`ifdef MEM_BURST_SEQ_STALL_CNT_EN
    ,
    .rd_stall_cnt (rd_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // memory bank array: synchronous write, combinational read
  logic [31:0] tb_mem [DEPTH];
  always @(posedge clk) if (mem_write) tb_mem[mem_address] <= mem_data_in;
  assign mem_data_out = tb_mem[mem_address];

  logic [31:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    bit          mode;
    int          base;
    int          len;
    logic [31:0] dbase;
    int          stall_idx;
    int          stall_cyc;
    int          extra_k;
    int          exp_done_k;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_wr_ready"}, 64'(wr_ready), 0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 0);
    check({tag, "_rd_data"}, 64'(rd_data), 0);
    check({tag, "_mem_rw"}, 64'({mem_read, mem_write}), 0);
    check({tag, "_mem_address"}, 64'(mem_address), 0);
    check({tag, "_mem_data_in"}, 64'(mem_data_in), 0);
`ifdef MEM_BURST_SEQ_STALL_CNT_EN
    check({tag, "_stall_cnt"}, 64'(rd_stall_cnt), 0);
`endif
  endtask

  // Cycle k counts negedges after the edge that sampled start (k=1 is the
  // first cycle after acceptance). Observation happens at each negedge.
  task automatic run_burst(input vec_t v, input bit rnd);
    int l_eff, n_wr, n_rd;
    logic [31:0] exp_w[$];
    logic [31:0] got_r[$];
    logic [3:0]  w_addr_q[$];
    logic [31:0] w_data_q[$];
    int k, acc, hs, stalled, k_done, k_busy, k_rv, done_cnt, rd_cnt, stall_seen, unstable;
    bit prev_hold;
    logic [31:0] prev_data;

    l_eff = (v.len > DEPTH) ? DEPTH : v.len;
    n_wr = v.mode ? 0 : l_eff;
    n_rd = v.mode ? l_eff : 0;
    for (int i = 0; i < n_wr; i++) exp_w.push_back(v.dbase + 32'(i));
    acc = 0; hs = 0; stalled = 0; k_done = -1; k_busy = -1; k_rv = -1;
    done_cnt = 0; rd_cnt = 0; stall_seen = 0; unstable = 0; prev_hold = 0; prev_data = '0;

    @(negedge clk);
    start = 1'b1; mode = v.mode; base_addr = 4'(v.base); len = 5'(v.len);
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 400) begin
      if (done) begin done_cnt++; k_done = k; end
      if (busy && k_busy < 0) k_busy = k;
      if (rd_valid && k_rv < 0) k_rv = k;
      if (mem_write) begin w_addr_q.push_back(mem_address); w_data_q.push_back(mem_data_in); end
      if (mem_read) rd_cnt++;
      if (rd_valid && prev_hold && rd_data !== prev_data) unstable++;
      if (k_done >= 0) break;

      start = (k == v.extra_k);
      if (start) begin mode = ~v.mode; base_addr = 4'(v.base + 5); len = 5'd2; end
      if (acc < n_wr) begin
        wr_data = exp_w[acc];
        wr_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else begin
        wr_data = $urandom;
        wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (wr_valid && wr_ready) acc++;
      if (rd_valid) begin
        if (hs == v.stall_idx && stalled < v.stall_cyc) begin
          rd_ready = 1'b0; stalled++;
        end else begin
          rd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (rd_ready) begin got_r.push_back(rd_data); hs++; end
        else stall_seen++;
      end else begin
        rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      @(negedge clk);
      k++;
    end
    start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (mem_write) begin w_addr_q.push_back(mem_address); w_data_q.push_back(mem_data_in); end
      if (mem_read) rd_cnt++;
    end

    check("done_count", 64'(done_cnt), 1);
    if (v.exp_done_k >= 0) check("done_cycle", 64'(k_done), 64'(v.exp_done_k));
    check("busy_rise", 64'(k_busy), (l_eff > 0) ? 64'(1) : 64'(-1));
    check("busy_after_done", 64'(busy), 0);
    check("write_count", 64'(w_addr_q.size()), 64'(n_wr));
    for (int i = 0; i < n_wr && i < w_addr_q.size(); i++) begin
      check("write_addr", 64'(w_addr_q[i]), 64'((v.base + i) % DEPTH));
      check("write_data", 64'(w_data_q[i]), 64'(exp_w[i]));
    end
    for (int i = 0; i < n_wr; i++) ref_mem[(v.base + i) % DEPTH] = exp_w[i];
    check("read_count", 64'(got_r.size()), 64'(n_rd));
    check("mem_read_count", 64'(rd_cnt), 64'(n_rd));
    for (int i = 0; i < n_rd && i < got_r.size(); i++)
      check("read_data", 64'(got_r[i]), 64'(ref_mem[(v.base + i) % DEPTH]));
    if (n_rd > 0) begin
      check("first_rd_valid", 64'(k_rv), 3);
      check("rd_data_stable", 64'(unstable), 0);
    end
`ifdef MEM_BURST_SEQ_STALL_CNT_EN
    check("stall_cnt", 64'(rd_stall_cnt), 64'(stall_seen));
`endif
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int pulses, acc;
    bit seen_done;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    //            mode base len dbase          stall_idx cyc extra_k done_k
    vecs.push_back('{1'b0, 0,  16, 32'h1000_0000, -1, 0, -1, 33});
    vecs.push_back('{1'b1, 0,  16, 32'h0,          -1, 0, -1, 49});
    vecs.push_back('{1'b0, 14, 4,  32'hA5A5_0000, -1, 0, -1, 9});
    vecs.push_back('{1'b1, 14, 4,  32'h0,          -1, 0, -1, 13});
    vecs.push_back('{1'b1, 0,  3,  32'h0,           1, 5, -1, 15});
    vecs.push_back('{1'b0, 0,  0,  32'h0,          -1, 0, -1, 1});
    vecs.push_back('{1'b0, 2,  8,  32'h7700_0000, -1, 0,  4, 17});
    vecs.push_back('{1'b0, 5,  20, 32'h3C00_0000, -1, 0, -1, 33});
    vecs.push_back('{1'b1, 5,  20, 32'h0,          -1, 0, -1, 49});
    vecs.push_back('{1'b1, 0,  0,  32'h0,          -1, 0, -1, 1});
    vecs.push_back('{1'b1, 15, 1,  32'h0,          -1, 0, -1, 4});

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_burst(vecs[i], 1'b0);

    // reset in the middle of an 8-word write, after the 5th word lands
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 4'd0; len = 5'd8;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; acc = 0; seen_done = 0;
    for (int k = 0; k < 100 && pulses < 5; k++) begin
      if (mem_write) pulses++;
      if (done) seen_done = 1;
      if (pulses < 5) begin
        wr_data = 32'hBEEF_0000 + 32'(acc);
        wr_valid = 1'b1;
        if (wr_ready) acc++;
        @(negedge clk);
      end
    end
    check("reset_test_pulses", 64'(pulses), 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("reset_no_done", 64'(seen_done), 0);
    check("reset_busy_low", 64'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      check("reset_partial_mem", 64'(tb_mem[i]), 64'(32'hBEEF_0000 + 32'(i)));
      ref_mem[i] = 32'hBEEF_0000 + 32'(i);
    end
    check("reset_word5_untouched", 64'(tb_mem[5]), 64'(ref_mem[5]));
    v = '{1'b0, 7, 1, 32'h0DDC_0001, -1, 0, -1, 3};
    run_burst(v, 1'b0);
    v = '{1'b1, 0, 8, 32'h0, -1, 0, -1, 25};
    run_burst(v, 1'b0);

    for (int r = 0; r < 24; r++) begin
      v.mode       = 1'($urandom_range(0, 1));
      v.base       = int'($urandom_range(0, 15));
      v.len        = int'($urandom_range(0, 20));
      v.dbase      = $urandom;
      v.stall_idx  = -1;
      v.stall_cyc  = 0;
      v.extra_k    = ($urandom_range(0, 1) != 0) ? 3 : -1;
      v.exp_done_k = -1;
      run_burst(v, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
